// File: rtl/oyun_tx.sv
// oyun_tx: captures a three-round oyun game record on start and streams one round per
// valid/ready frame with per-round points, win flag and the final result O.
// Optional build macro OYUN_EARLY_STOP_EN ends the stream once the result is decided.
module oyun_tx #(
  parameter  int NUM_ROUNDS = 3,
  parameter  int WIN_THRESH = 5,
  parameter  int MAJORITY   = NUM_ROUNDS / 2 + 1,
  localparam int IDX_W      = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1,
  localparam int CNT_W      = $clog2(NUM_ROUNDS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [8*NUM_ROUNDS-1:0] game_in,
  output logic                    busy,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic [7:0]              frame_data,
  output logic [IDX_W-1:0]        frame_idx,
  output logic [1:0]              p1_pts,
  output logic [1:0]              p2_pts,
  output logic                    round_win,
  output logic [CNT_W-1:0]        wins_cnt,
  output logic                    done,
  output logic                    O
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ROUNDS - 1);

  state_t                         state, state_nxt;
  logic [NUM_ROUNDS-1:0][7:0]     shadow;
  logic [IDX_W-1:0]               idx;
  logic [7:0]                     cur;
  logic [1:0]                     p1_c, p2_c;
  logic [2:0]                     sum;
  logic                           win_c, accept, stop, maj;
  logic [CNT_W-1:0]               wins_nxt;
`ifdef OYUN_EARLY_STOP_EN
  logic [CNT_W-1:0]               losses;
`endif

  function automatic logic [1:0] pts(input logic [1:0] x, input logic [1:0] y);
    if (x == 2'd0 || y == 2'd0) return 2'd0;
    if (x == 2'd2)              return (y == 2'd2) ? 2'd3 : 2'd2;
    return (y == 2'd2) ? 2'd2 : 2'd1;
  endfunction

  always_comb begin
    cur      = shadow[idx];
    p1_c     = pts(cur[7:6], cur[5:4]);
    p2_c     = pts(cur[3:2], cur[1:0]);
    sum      = {1'b0, p1_c} + {1'b0, p2_c};
    win_c    = 32'(sum) >= WIN_THRESH;
    accept   = (state == SEND) && frame_ready;
    wins_nxt = wins_cnt + CNT_W'(win_c);
    maj      = 32'(wins_nxt) >= MAJORITY;
    stop     = (idx == LAST);
`ifdef OYUN_EARLY_STOP_EN
    // idx+1 frames have been accepted once this one goes, so the rest are losses
    losses   = CNT_W'(idx) + CNT_W'(1) - wins_nxt;
    stop     = stop || maj || (32'(losses) > NUM_ROUNDS - MAJORITY);
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SEND;
      SEND:    if (accept && stop) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    frame_valid = (state == SEND);
    busy        = frame_valid;
    done        = (state == DONE);
    frame_data  = frame_valid ? cur   : 8'd0;
    frame_idx   = frame_valid ? idx   : '0;
    p1_pts      = frame_valid ? p1_c  : 2'd0;
    p2_pts      = frame_valid ? p2_c  : 2'd0;
    round_win   = frame_valid & win_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow   <= '0;
      idx      <= '0;
      wins_cnt <= '0;
      O        <= 1'b0;
    end else if (state == IDLE && start) begin
      shadow   <= game_in;
      idx      <= '0;
      wins_cnt <= '0;
      O        <= 1'b0;
    end else if (accept) begin
      wins_cnt <= wins_nxt;
      if (stop) O   <= maj;
      else      idx <= idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_oyun_tx.sv
// Directed self-checking bench for oyun_tx (3 rounds, threshold 5, majority 2).
module tb_oyun_tx;
  logic        clk = 1'b0;
  logic        rst_n, start, frame_ready;
  logic [23:0] game_in;
  logic        busy, frame_valid, round_win, done, O;
  logic [7:0]  frame_data;
  logic [1:0]  frame_idx, p1_pts, p2_pts, wins_cnt;
  int checks = 0;
  int failures = 0;

`ifdef OYUN_EARLY_STOP_EN
  localparam int NF_AW = 2, NF_ZERO = 2, NF_MIX = 2;
`else
  localparam int NF_AW = 3, NF_ZERO = 3, NF_MIX = 3;
`endif

  oyun_tx dut (
    .clk(clk), .rst_n(rst_n), .start(start), .game_in(game_in), .busy(busy),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
    .frame_idx(frame_idx), .p1_pts(p1_pts), .p2_pts(p2_pts), .round_win(round_win),
    .wins_cnt(wins_cnt), .done(done), .O(O)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [23:0] g);
    start = 1'b1; game_in = g;
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || done || frame_valid) && n < 20) begin tick(); n++; end
    checks++;
    if (busy || done || frame_valid) begin
      failures++; $display("FAIL drain timeout busy=%b done=%b valid=%b", busy, done, frame_valid);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, frame_valid, done, O, wins_cnt, frame_idx, frame_data, p1_pts, p2_pts, round_win} !== 21'd0) begin
      failures++;
      $display("FAIL reset outputs got %h want 0",
               {busy, frame_valid, done, O, wins_cnt, frame_idx, frame_data, p1_pts, p2_pts, round_win});
    end
  endtask

  task automatic test_all_win();
    launch({8'hAA, 8'hAA, 8'hAA});
    for (int i = 0; i < NF_AW; i++) begin
      checks++;
      if ({frame_valid, busy, frame_idx, frame_data, p1_pts, p2_pts, round_win, wins_cnt} !==
          {1'b1, 1'b1, 2'(i), 8'hAA, 2'd3, 2'd3, 1'b1, 2'(i)}) begin
        failures++;
        $display("FAIL all_win frame%0d got v=%b b=%b idx=%0d d=%h p=%0d/%0d w=%b cnt=%0d", i,
                 frame_valid, busy, frame_idx, frame_data, p1_pts, p2_pts, round_win, wins_cnt);
      end
      tick();
    end
    checks++;
    if ({done, O, busy, frame_valid, wins_cnt} !== {1'b1, 1'b1, 1'b0, 1'b0, 2'(NF_AW)}) begin
      failures++;
      $display("FAIL all_win done got done=%b O=%b busy=%b v=%b cnt=%0d want 1 1 0 0 %0d",
               done, O, busy, frame_valid, wins_cnt, NF_AW);
    end
    tick();
    checks++;
    if ({done, O, busy} !== 3'b010) begin
      failures++; $display("FAIL all_win hold got done=%b O=%b busy=%b want 0 1 0", done, O, busy);
    end
  endtask

  task automatic test_all_zero();
    launch(24'h000000);
    checks++;
    if ({O, wins_cnt} !== 3'b000) begin
      failures++; $display("FAIL zero start_clear got O=%b cnt=%0d want 0 0", O, wins_cnt);
    end
    for (int i = 0; i < NF_ZERO; i++) begin
      checks++;
      if ({frame_valid, frame_idx, frame_data, p1_pts, p2_pts, round_win, wins_cnt} !==
          {1'b1, 2'(i), 8'h00, 2'd0, 2'd0, 1'b0, 2'd0}) begin
        failures++;
        $display("FAIL zero frame%0d got v=%b idx=%0d d=%h p=%0d/%0d w=%b cnt=%0d", i,
                 frame_valid, frame_idx, frame_data, p1_pts, p2_pts, round_win, wins_cnt);
      end
      tick();
    end
    checks++;
    if ({done, O, frame_valid} !== 3'b100) begin
      failures++; $display("FAIL zero done got done=%b O=%b v=%b want 1 0 0", done, O, frame_valid);
    end
    drain();
  endtask

  task automatic test_mixed();
    logic [7:0] ed [3] = '{8'hA7, 8'h55, 8'h9B};
    logic [1:0] e1 [3] = '{2'd3, 2'd1, 2'd2};
    logic [1:0] e2 [3] = '{2'd1, 2'd1, 2'd2};
    launch({8'h9B, 8'h55, 8'hA7});
    for (int i = 0; i < NF_MIX; i++) begin
      checks++;
      if ({frame_valid, frame_idx, frame_data, p1_pts, p2_pts, round_win} !==
          {1'b1, 2'(i), ed[i], e1[i], e2[i], 1'b0}) begin
        failures++;
        $display("FAIL mixed frame%0d got idx=%0d d=%h p=%0d/%0d w=%b want d=%h p=%0d/%0d w=0", i,
                 frame_idx, frame_data, p1_pts, p2_pts, round_win, ed[i], e1[i], e2[i]);
      end
      tick();
    end
    checks++;
    if ({done, O, wins_cnt} !== 4'b1000) begin
      failures++; $display("FAIL mixed done got done=%b O=%b cnt=%0d want 1 0 0", done, O, wins_cnt);
    end
    drain();
  endtask

  task automatic test_sums_640();
    logic [7:0] ed [3] = '{8'hAA, 8'hE9, 8'h00};
    logic [1:0] e1 [3] = '{2'd3, 2'd2, 2'd0};
    logic [1:0] e2 [3] = '{2'd3, 2'd2, 2'd0};
    logic       ew [3] = '{1'b1, 1'b0, 1'b0};
    launch({8'h00, 8'hE9, 8'hAA});
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({frame_valid, frame_idx, frame_data, p1_pts, p2_pts, round_win} !==
          {1'b1, 2'(i), ed[i], e1[i], e2[i], ew[i]}) begin
        failures++;
        $display("FAIL sums640 frame%0d got idx=%0d d=%h p=%0d/%0d w=%b want d=%h p=%0d/%0d w=%b", i,
                 frame_idx, frame_data, p1_pts, p2_pts, round_win, ed[i], e1[i], e2[i], ew[i]);
      end
      tick();
    end
    checks++;
    if ({done, O, wins_cnt} !== 4'b1001) begin
      failures++; $display("FAIL sums640 done got done=%b O=%b cnt=%0d want 1 0 1", done, O, wins_cnt);
    end
    drain();
  endtask

  task automatic test_backpressure();
    launch({8'hAA, 8'hAA, 8'hAA});
    tick();
    frame_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({frame_valid, frame_idx, frame_data, wins_cnt} !== {1'b1, 2'd1, 8'hAA, 2'd1}) begin
        failures++;
        $display("FAIL backpressure cycle%0d got v=%b idx=%0d d=%h cnt=%0d want 1 1 aa 1", c,
                 frame_valid, frame_idx, frame_data, wins_cnt);
      end
      tick();
    end
    frame_ready = 1'b1;
    tick();
    checks++;
    if (wins_cnt !== 2'd2) begin
      failures++; $display("FAIL backpressure accept got cnt=%0d want 2", wins_cnt);
    end
    drain();
  endtask

  task automatic test_back_to_back_start();
    int nf = 0;
    int n = 0;
    launch({8'hAA, 8'hAA, 8'hAA});
    start = 1'b1; game_in = 24'h000000;
    while (!done && n < 20) begin
      if (frame_valid) begin
        checks++;
        if ({frame_idx, frame_data, p1_pts} !== {2'(nf), 8'hAA, 2'd3}) begin
          failures++;
          $display("FAIL busy_start frame%0d got idx=%0d d=%h p1=%0d want %0d aa 3", nf,
                   frame_idx, frame_data, p1_pts, nf);
        end
        nf++;
      end
      tick();
      start = 1'b0;
      n++;
    end
    checks++;
    if (!done || O !== 1'b1 || nf != NF_AW) begin
      failures++; $display("FAIL busy_start end got done=%b O=%b frames=%0d want 1 1 %0d", done, O, nf, NF_AW);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    logic seen_done = 1'b0;
    launch({8'hAA, 8'hAA, 8'hAA});
    tick();
    checks++;
    if (frame_idx !== 2'd1) begin
      failures++; $display("FAIL reset_mid setup got idx=%0d want 1", frame_idx);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({frame_valid, busy, done, O, wins_cnt, frame_idx, frame_data} !== 15'd0) begin
      failures++;
      $display("FAIL reset_mid abort got v=%b b=%b done=%b O=%b cnt=%0d idx=%0d d=%h want all 0",
               frame_valid, busy, done, O, wins_cnt, frame_idx, frame_data);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (done || frame_valid) seen_done = 1'b1;
      tick();
    end
    checks++;
    if (seen_done !== 1'b0) begin
      failures++; $display("FAIL reset_mid activity got done/valid=%b want 0", seen_done);
    end
  endtask

  task automatic test_restart();
    launch({8'h00, 8'h00, 8'h55});
    checks++;
    if ({frame_valid, frame_idx, frame_data, p1_pts, wins_cnt} !== {1'b1, 2'd0, 8'h55, 2'd1, 2'd0}) begin
      failures++;
      $display("FAIL restart got v=%b idx=%0d d=%h p1=%0d cnt=%0d want 1 0 55 1 0",
               frame_valid, frame_idx, frame_data, p1_pts, wins_cnt);
    end
    drain();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; frame_ready = 1'b1; game_in = '0;
    #3;
    test_reset();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    test_all_win();
    test_all_zero();
    test_mixed();
    test_sums_640();
    test_backpressure();
    test_back_to_back_start();
    test_reset_mid();
    test_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/oyun_tx.md
Name: oyun_tx

Overview:
- Sequential transmitter for the two-player, three-round "oyun" game.
- Captures a complete parallel game record on start and streams it one round per frame over a valid/ready handshake.
- Drives the per-round points, a per-round win flag and the final game result alongside each frame.
- Sits in front of a serial referee/display path and feeds it the same data the parallel oyun judge consumes.

Parameters:
NUM_ROUNDS, 3, number of rounds per game (odd, >=1)
WIN_THRESH, 5, minimum P1+P2 point sum for a round to count as won
MAJORITY, 2, minimum won rounds for O=1 (default = NUM_ROUNDS/2+1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  load game_in and begin transmission; honoured only when busy=0
game_in  input  8*NUM_ROUNDS  round r in bits [8r+7:8r] = {X1,Y1,X2,Y2}, 2 bits each
busy  output  1  high from the cycle after an accepted start until the cycle done pulses
frame_valid  output  1  frame_data/frame_idx/pts valid
frame_ready  input  1  downstream accepts the frame when frame_valid&&frame_ready
frame_data  output  8  {X1,Y1,X2,Y2} of the current round
frame_idx  output  clog2(NUM_ROUNDS)  index of the current round, 0-based
p1_pts  output  2  points of player 1 for the current round
p2_pts  output  2  points of player 2 for the current round
round_win  output  1  p1_pts+p2_pts >= WIN_THRESH
wins_cnt  output  clog2(NUM_ROUNDS+1)  won rounds among frames already accepted
done  output  1  one-cycle pulse after the final accepted frame
O  output  1  game result (wins >= MAJORITY); valid on done, held until next start

Behaviour:
- Reset (asynchronous, any state): state=IDLE. busy, frame_valid, done, O, wins_cnt, frame_idx, frame_data, p1_pts, p2_pts and round_win all = 0.
- Point function P(X,Y), 2-bit result:
  - 0 if X==0 or Y==0.
  - X=1: Y=1/2/3 -> 1/2/1.
  - X=2: Y=1/2/3 -> 2/3/2.
  - X=3: Y=1/2/3 -> 1/2/1.
- Player points: p1_pts = P(X1,Y1), p2_pts = P(X2,Y2).
- Sum is 3 bits wide and does not overflow (max 6).
- States: IDLE, SEND, DONE.
- IDLE:
  - start=1 registers game_in into the shadow register and clears wins_cnt and O.
  - Next cycle: SEND with idx=0 and frame_valid=1.
  - Latency from start to first frame_valid is 1 cycle.
- SEND:
  - frame_data, frame_idx, pts and round_win are combinational from the shadow register at idx.
  - All of them stay stable while frame_valid && !frame_ready.
  - On accept: wins_cnt += round_win.
  - If idx == NUM_ROUNDS-1: go to DONE, frame_valid drops the next cycle.
  - Otherwise idx+1 and frame_valid stays high, so back-to-back frames stream at 1 per cycle.
- DONE:
  - done=1 for exactly one cycle.
  - O = (final wins_cnt >= MAJORITY).
  - Then IDLE; busy falls in the same cycle done pulses.
- start while busy=1 or in DONE is ignored; game_in changes after capture have no effect.
- frame_ready while frame_valid=0 is ignored.
- Reset asserted mid-game aborts immediately: no done pulse, all outputs return to reset values.
- Within one cycle, start is evaluated only in IDLE, so start and accept cannot conflict.

Optional Feature:
OYUN_EARLY_STOP_EN
- Defined:
  - After each accept, if wins >= MAJORITY, or losses > NUM_ROUNDS-MAJORITY, the block jumps to DONE.
  - Remaining frames are not sent; O is decided from the frames already accepted.
  - frame_idx of the last frame sent can be less than NUM_ROUNDS-1.
- Undefined: all NUM_ROUNDS frames are always sent.
- O is identical in both builds for any input.

Test Plan:
- All rounds {2,2,2,2}, frame_ready=1 -> frames at cycles 1,2,3, each p1=p2=3, round_win=1; done on cycle 4 with O=1, wins_cnt=3.
- All zeros -> three frames with pts 0, round_win=0; done with O=0.
- Rounds {2,2,1,3},{1,1,1,1},{2,1,2,3} (sums 4,2,4) -> O=0.
- Backpressure: frame_ready low for 5 cycles on frame 1 -> frame_data and frame_idx=1 held stable all 5 cycles; wins_cnt unchanged until accept.
- Rounds {2,2,2,2},{3,2,2,1},{0,0,0,0} (sums 6,4,0) -> O=0.
- With OYUN_EARLY_STOP_EN: first two rounds {2,2,2,2} -> only 2 frames sent, done after frame 1, O=1.
- Without OYUN_EARLY_STOP_EN, same first two rounds -> 3 frames, O=1.
- start pulsed while busy with a different game_in -> ignored, original stream continues unchanged.
- rst_n low while frame_idx=1 -> frame_valid=0 at once, no done pulse.
- A new start after reset -> restarts at frame_idx=0.
